qlearn_episode_ctrl: RTL and testbench

Sequencer that drives the 4-stage Q-learning update pipeline. It owns the agent's grid position and selects one action per cycle with epsilon-greedy exploration (LFSR). It inserts bubbles on read-after-write state hazards and runs episodes from a start cell until the goal cell or a step limit. Sits directly upstream of the pipeline's action input and replaces its free-running state walk.

---
 rtl/qlearn_episode_ctrl.sv | 151 +++++++++++++++
 tb/tb_qlearn_episode_ctrl.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/qlearn_episode_ctrl.sv
// Episode sequencer for the 4-stage Q-learning update pipeline: owns the agent
// position, picks epsilon-greedy actions, inserts hazard bubbles and counts episodes.
module qlearn_episode_ctrl #(
  parameter logic [5:0]  START_STATE  = 6'o00,
  parameter logic [5:0]  GOAL_STATE   = 6'o77,
  parameter int          MAX_STEPS    = 256,
  parameter int          NUM_EPISODES = 100,
  parameter int          PIPE_DEPTH   = 4,
  parameter logic [15:0] SEED         = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  epsilon,
  input  logic [1:0]  greedy_action,
  output logic [1:0]  action,
  output logic        action_valid,
  output logic [5:0]  cur_state,
  output logic [8:0]  step_cnt,
  output logic [15:0] episode_cnt,
  output logic        episode_done,
  output logic        busy,
  output logic        done
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam int          HZ         = PIPE_DEPTH - 1;
  localparam int          DW         = $clog2(PIPE_DEPTH + 1);
  localparam logic [DW-1:0] DRAIN_LAST = DW'(PIPE_DEPTH - 1);
  localparam logic [8:0]  STEP_LAST  = 9'(MAX_STEPS - 1);
  localparam logic [15:0] EP_LAST    = 16'(NUM_EPISODES - 1);

  logic [1:0]    state;
  logic [1:0]    state_nxt;
  logic [15:0]   lfsr;
  logic          lfsr_fb;
  logic [DW-1:0] drain_cnt;
  logic [5:0]    hz_state [HZ];
  logic          hz_valid [HZ];

  logic          explore;
  logic [1:0]    sel_action;
  logic [2:0]    pos_x;
  logic [2:0]    pos_y;
  logic [5:0]    next_pos;
  logic          hazard;
  logic          issue_last;
  logic          drain_last;

  assign lfsr_fb    = lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5];
  assign explore    = lfsr[7:0] < epsilon;
  assign sel_action = explore ? lfsr[9:8] : greedy_action;
  assign pos_x      = cur_state[5:3];
  assign pos_y      = cur_state[2:0];
  assign drain_last = drain_cnt == DRAIN_LAST;

  // One-cell move with wall saturation; a bounce leaves the position unchanged.
  always_comb begin
    next_pos = cur_state;
    case (sel_action)
      2'b00: if (pos_x != 3'd0) next_pos = {pos_x - 3'd1, pos_y};
      2'b01: if (pos_y != 3'd0) next_pos = {pos_x, pos_y - 3'd1};
      2'b10: if (pos_x != 3'd7) next_pos = {pos_x + 3'd1, pos_y};
      default: if (pos_y != 3'd7) next_pos = {pos_x, pos_y + 3'd1};
    endcase
  end

  always_comb begin
    hazard = 1'b0;
    for (int unsigned i = 0; i < HZ; i++) begin
      if (hz_valid[i] && (hz_state[i] == cur_state)) hazard = 1'b1;
    end
  end

  assign issue_last = (next_pos == GOAL_STATE) || (step_cnt == STEP_LAST);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_RUN;
      S_RUN:   if (!hazard && issue_last) state_nxt = S_DRAIN;
      S_DRAIN: if (drain_last) state_nxt = (episode_cnt == EP_LAST) ? S_DONE : S_RUN;
      default: state_nxt = S_DONE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= S_IDLE;
      lfsr         <= SEED;
      drain_cnt    <= '0;
      cur_state    <= START_STATE;
      step_cnt     <= '0;
      episode_cnt  <= '0;
      action       <= '0;
      action_valid <= 1'b0;
      episode_done <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      for (int unsigned i = 0; i < HZ; i++) begin
        hz_state[i] <= '0;
        hz_valid[i] <= 1'b0;
      end
    end else begin
      state        <= state_nxt;
      busy         <= (state_nxt == S_RUN) || (state_nxt == S_DRAIN);
      done         <= state_nxt == S_DONE;
      action_valid <= 1'b0;
      episode_done <= 1'b0;
      if (state != S_IDLE) lfsr <= {lfsr_fb, lfsr[15:1]};

      case (state)
        S_RUN: begin
          action <= sel_action;
          for (int unsigned i = 1; i < HZ; i++) begin
            hz_state[i] <= hz_state[i-1];
            hz_valid[i] <= hz_valid[i-1];
          end
          if (hazard) begin
            hz_valid[0] <= 1'b0;
          end else begin
            hz_state[0]  <= cur_state;
            hz_valid[0]  <= 1'b1;
            action_valid <= 1'b1;
            cur_state    <= next_pos;
            step_cnt     <= step_cnt + 9'd1;
            if (issue_last) drain_cnt <= '0;
          end
        end
        S_DRAIN: begin
          drain_cnt <= drain_cnt + 1'b1;
          if (drain_last) begin
            episode_cnt  <= episode_cnt + 16'd1;
            episode_done <= 1'b1;
            for (int unsigned i = 0; i < HZ; i++) hz_valid[i] <= 1'b0;
            if (episode_cnt != EP_LAST) begin
              cur_state <= START_STATE;
              step_cnt  <= '0;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_qlearn_episode_ctrl.sv
// Scoreboard bench: a cycle-stepped reference model pushes expected issues and
// episode ends into queues; a negedge monitor pops and compares against the DUT.
module tb_qlearn_episode_ctrl;

  localparam logic [5:0]  START = 6'o00;
  localparam logic [5:0]  GOAL  = 6'o70;
  localparam int          MAXS  = 12;
  localparam int          NEPI  = 4;
  localparam int          PIPE  = 4;
  localparam logic [15:0] SEEDV = 16'hACE1;

  localparam int M_IDLE = 0, M_RUN = 1, M_DRAIN = 2, M_DONE = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  epsilon;
  logic [1:0]  greedy_action;
  logic [1:0]  action;
  logic        action_valid;
  logic [5:0]  cur_state;
  logic [8:0]  step_cnt;
  logic [15:0] episode_cnt;
  logic        episode_done;
  logic        busy;
  logic        done;

  logic        use_tab;
  logic [1:0]  fixed_act;
  logic [1:0]  tab [64];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  qlearn_episode_ctrl #(
    .START_STATE(START), .GOAL_STATE(GOAL), .MAX_STEPS(MAXS),
    .NUM_EPISODES(NEPI), .PIPE_DEPTH(PIPE), .SEED(SEEDV)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .epsilon(epsilon),
    .greedy_action(greedy_action), .action(action), .action_valid(action_valid),
    .cur_state(cur_state), .step_cnt(step_cnt), .episode_cnt(episode_cnt),
    .episode_done(episode_done), .busy(busy), .done(done)
  );

  // Stand-in for the argmax lookup, keyed by the DUT's current cell.
  always_comb greedy_action = use_tab ? tab[cur_state] : fixed_act;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      if (errors <= 40) $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    if (errors <= 40) $display("FAIL %s actual=absent required=present", name);
  endtask

  // ---------------- reference model ----------------
  typedef struct { int stamp; int act; int step; int pos; } act_t;
  typedef struct { int stamp; int epi; int pos; int step; } epi_t;
  act_t act_q[$];
  epi_t epi_q[$];
  int   hist[$];
  int   cyc = 0;
  int   mst, m_pos, m_steps, m_epi, m_dcnt, m_lfsr;

  function automatic int move(input int p, input int a);
    int x, y;
    x = p / 8;
    y = p % 8;
    case (a)
      0: if (x > 0) x--;
      1: if (y > 0) y--;
      2: if (x < 7) x++;
      default: if (y < 7) y++;
    endcase
    return x * 8 + y;
  endfunction

  function automatic int lfsr_step(input int l);
    int b;
    b = ((l >> 0) ^ (l >> 2) ^ (l >> 3) ^ (l >> 5)) & 1;
    return (l >> 1) | (b << 15);
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mst = M_IDLE; m_pos = START; m_steps = 0; m_epi = 0; m_dcnt = 0;
      m_lfsr = SEEDV;
      hist.delete(); act_q.delete(); epi_q.delete();
    end else begin
      cyc++;
      case (mst)
        M_IDLE: if (start) mst = M_RUN;
        M_RUN: begin
          int g, a, np;
          bit hz;
          g = use_tab ? tab[m_pos] : fixed_act;
          a = ((m_lfsr & 255) < epsilon) ? ((m_lfsr >> 8) & 3) : g;
          hz = 0;
          foreach (hist[i]) if (hist[i] == m_pos) hz = 1;
          if (hz) begin
            hist.push_front(-1);
          end else begin
            np = move(m_pos, a);
            hist.push_front(m_pos);
            m_steps++;
            act_q.push_back('{cyc, a, m_steps, np});
            m_pos = np;
            if (np == GOAL || m_steps == MAXS) begin
              mst = M_DRAIN;
              m_dcnt = 0;
            end
          end
          while (hist.size() > PIPE - 1) void'(hist.pop_back());
          m_lfsr = lfsr_step(m_lfsr);
        end
        M_DRAIN: begin
          m_dcnt++;
          m_lfsr = lfsr_step(m_lfsr);
          if (m_dcnt == PIPE) begin
            m_epi++;
            hist.delete();
            if (m_epi == NEPI) begin
              mst = M_DONE;
            end else begin
              m_pos = START; m_steps = 0; mst = M_RUN;
            end
            epi_q.push_back('{cyc, m_epi, m_pos, m_steps});
          end
        end
        default: m_lfsr = lfsr_step(m_lfsr);
      endcase
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (rst) begin
      while (act_q.size() > 0 && act_q[0].stamp < cyc) begin
        fail_now("action_missing");
        void'(act_q.pop_front());
      end
      while (epi_q.size() > 0 && epi_q[0].stamp < cyc) begin
        fail_now("episode_done_missing");
        void'(epi_q.pop_front());
      end
      if (action_valid) begin
        if (act_q.size() == 0 || act_q[0].stamp != cyc) begin
          check("unexpected_action_valid", 1, 0);
        end else begin
          act_t e;
          e = act_q.pop_front();
          check("action", action, e.act);
          check("step_cnt", step_cnt, e.step);
          check("cur_state_after_issue", cur_state, e.pos);
        end
      end
      if (episode_done) begin
        if (epi_q.size() == 0 || epi_q[0].stamp != cyc) begin
          check("unexpected_episode_done", 1, 0);
        end else begin
          epi_t e;
          e = epi_q.pop_front();
          check("episode_cnt", episode_cnt, e.epi);
          check("cur_state_after_episode", cur_state, e.pos);
          check("step_cnt_after_episode", step_cnt, e.step);
        end
      end
      check("busy", busy, (mst == M_RUN || mst == M_DRAIN) ? 1 : 0);
      check("done", done, (mst == M_DONE) ? 1 : 0);
    end
  end

  // ---------------- stimulus ----------------
  task automatic check_reset(input string tag);
    check({tag, "_cur_state"}, cur_state, START);
    check({tag, "_step_cnt"}, step_cnt, 0);
    check({tag, "_episode_cnt"}, episode_cnt, 0);
    check({tag, "_action"}, action, 0);
    check({tag, "_action_valid"}, action_valid, 0);
    check({tag, "_episode_done"}, episode_done, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic wait_episode(input int budget, input bit rand_eps);
    bit seen = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (rand_eps) epsilon = 8'($urandom_range(0, 255));
      if (episode_done) begin
        seen = 1;
        break;
      end
    end
    if (!seen) fail_now("episode_timeout");
  endtask

  task automatic wait_done(input int budget);
    bit seen = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      epsilon = 8'($urandom_range(0, 255));
      if (done) begin
        seen = 1;
        break;
      end
    end
    if (!seen) fail_now("done_timeout");
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; epsilon = 8'd0; use_tab = 1'b0; fixed_act = 2'b10;
    for (int i = 0; i < 64; i++) tab[i] = 2'($urandom_range(0, 3));
    repeat (3) @(negedge clk);
    check_reset("reset");
    rst = 1'b1;

    // Episode 1: pure greedy right walk to the goal at x=7.
    pulse_start();
    wait_episode(200, 0);
    // Episode 2: greedy left at x=0, every issue bounces until the step limit.
    fixed_act = 2'b00;
    wait_episode(200, 0);
    // Episode 3: full exploration from the LFSR.
    use_tab = 1'b1; epsilon = 8'd255;
    wait_episode(200, 0);
    // Episode 4: per-cycle random epsilon over a random greedy table.
    wait_done(300);
    check("done_level", done, 1);
    check("busy_after_done", busy, 0);
    pulse_start();
    repeat (10) @(negedge clk);
    check("done_holds", done, 1);
    check("episode_cnt_final", episode_cnt, NEPI);

    // Mid-run asynchronous reset, then a fresh run to completion.
    @(negedge clk) rst = 1'b0;
    @(negedge clk) rst = 1'b1;
    epsilon = 8'd128;
    pulse_start();
    begin
      bit seen = 0;
      for (int i = 0; i < 200; i++) begin
        @(negedge clk);
        if (step_cnt == 9'd3) begin
          seen = 1;
          break;
        end
      end
      if (!seen) fail_now("step3_timeout");
    end
    #2 rst = 1'b0;
    #1 check_reset("midrun_reset");
    repeat (2) @(negedge clk);
    rst = 1'b1;
    pulse_start();
    wait_done(1200);
    repeat (3) @(negedge clk);
    check("act_queue_left", act_q.size(), 0);
    check("epi_queue_left", epi_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end

endmodule
